axi_fifo_lvl: RTL and testbench

- Parametrised successor to the team's ready/valid FIFO.
- Arbitrary (non-power-of-two) depth with first-word-fall-through output.
- Adds a live occupancy count, runtime almost-full/almost-empty watermarks and a synchronous flush.
- Sits between rasteriser pipeline stages, e.g. vertex fetch to setup, and fragment to framebuffer writer, where back-pressure and early throttling are needed.

---
 rtl/axi_fifo_lvl_pkg.sv | 18 +
 rtl/axi_fifo_lvl_if.sv | 15 +
 rtl/axi_fifo_lvl_chk.sv | 16 +
 rtl/axi_fifo_lvl_ptr.sv | 41 ++++
 rtl/axi_fifo_lvl.sv | 163 ++++++++++++++++
 tb/tb_axi_fifo_lvl.sv | 218 +++++++++++++++++++++
 6 files changed

// File: rtl/axi_fifo_lvl_pkg.sv
// Shared types and helpers for the rasteriser-stage level-reporting FIFO.
// Build option AXI_FIFO_LVL_STATS_EN enables the statistics outputs of axi_fifo_lvl.
package rast_fifo_pkg;

    localparam int STALL_CNT_WIDTH  = 32;
    localparam int STATUS_CNT_WIDTH = 16;

    typedef struct packed {
        logic [STATUS_CNT_WIDTH-1:0] count;
        logic                        almost_full;
        logic                        almost_empty;
    } fifo_status_t;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/axi_fifo_lvl_if.sv
// Ready/valid bundle for both sides of axi_fifo_lvl.
// The slave modport is the FIFO and the master modport is its environment.
interface axi_fifo_lvl_if #(
    parameter int WIDTH = 64
) ();
    logic             vld_in;
    logic [WIDTH-1:0] data_in;
    logic             rdy_in;
    logic             vld_out;
    logic [WIDTH-1:0] data_out;
    logic             rdy_out;

    modport slave  (input  vld_in, data_in, rdy_out, output rdy_in, vld_out, data_out);
    modport master (output vld_in, data_in, rdy_out, input  rdy_in, vld_out, data_out);
endinterface

// File: rtl/axi_fifo_lvl_chk.sv
// Simulation checks on the upstream handshake of axi_fifo_lvl.
// A stalled word must be held stable; dropping vld_in without a handshake is allowed.
module axi_fifo_lvl_chk #(
    parameter int WIDTH = 64
) (
    input logic             clk,
    input logic             rst_n,
    input logic             vld_in,
    input logic             rdy_in,
    input logic [WIDTH-1:0] data_in
);
    a_stall_data_stable: assert property (
        @(posedge clk) disable iff (!rst_n)
        (vld_in && !rdy_in) |=> (!vld_in || $stable(data_in))
    );
endmodule

// File: rtl/axi_fifo_lvl_ptr.sv
// Wrapping index 0..DEPTH-1 for any DEPTH, with clear priority over increment.
// ptr_nxt is the wrapped successor of the current index.
module fifo_wrap_ptr #(
    parameter  int DEPTH     = 5,
    localparam int PTR_WIDTH = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    input  logic                 clr,
    output logic [PTR_WIDTH-1:0] ptr,
    output logic [PTR_WIDTH-1:0] ptr_nxt
);
    logic [PTR_WIDTH-1:0] ptr_r;
    logic [PTR_WIDTH-1:0] succ_s;

    // successor with explicit wrap at the last entry
    always_comb begin
        if (ptr_r == PTR_WIDTH'(DEPTH - 1)) begin
            succ_s = {PTR_WIDTH{1'b0}};
        end else begin
            succ_s = ptr_r + PTR_WIDTH'(1);
        end
    end

    // pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= {PTR_WIDTH{1'b0}};
        end else if (clr) begin
            ptr_r <= {PTR_WIDTH{1'b0}};
        end else if (inc) begin
            ptr_r <= succ_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign ptr     = ptr_r;
    assign ptr_nxt = succ_s;
endmodule

// File: rtl/axi_fifo_lvl.sv
// First-word-fall-through FIFO of any depth with occupancy, watermarks and flush.
// Define AXI_FIFO_LVL_STATS_EN to add peak_count and stall_cycles outputs.
module axi_fifo_lvl
    import rast_fifo_pkg::*;
#(
    parameter  int WIDTH     = 64,
    parameter  int DEPTH     = 5,
    localparam int PTR_WIDTH = $clog2(DEPTH),
    localparam int CNT_WIDTH = cnt_width(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    axi_fifo_lvl_if.slave              bus,
    input  logic [CNT_WIDTH-1:0]       af_thresh,
    input  logic [CNT_WIDTH-1:0]       ae_thresh,
    output logic [CNT_WIDTH-1:0]       count,
    output logic                       almost_full,
    output logic                       almost_empty
`ifdef AXI_FIFO_LVL_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]       peak_count,
    output logic [STALL_CNT_WIDTH-1:0] stall_cycles
`endif
);
    logic [WIDTH-1:0]     mem_r [DEPTH];
    logic [CNT_WIDTH-1:0] count_r;
    logic [CNT_WIDTH-1:0] count_nxt_s;
    logic [WIDTH-1:0]     data_out_r;
    logic [WIDTH-1:0]     data_nxt_s;
    logic                 vld_out_r;
    logic                 rdy_in_r;
    logic                 alive_r;
    logic                 push_s;
    logic                 pop_s;
    logic [PTR_WIDTH-1:0] wr_ptr_s;
    logic [PTR_WIDTH-1:0] wr_ptr_nxt_s;
    logic [PTR_WIDTH-1:0] rd_ptr_s;
    logic [PTR_WIDTH-1:0] rd_ptr_nxt_s;
    logic                 unused_wr_nxt_s;
    fifo_status_t         status_s;

    assign push_s          = bus.vld_in & rdy_in_r;
    assign pop_s           = vld_out_r & bus.rdy_out;
    assign unused_wr_nxt_s = ^wr_ptr_nxt_s;

    fifo_wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (push_s),
        .clr     (flush),
        .ptr     (wr_ptr_s),
        .ptr_nxt (wr_ptr_nxt_s)
    );

    fifo_wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (pop_s),
        .clr     (flush),
        .ptr     (rd_ptr_s),
        .ptr_nxt (rd_ptr_nxt_s)
    );

    // storage write; contents survive reset and flush
    always_ff @(posedge clk) begin
        if (push_s && !flush) begin
            mem_r[wr_ptr_s] <= bus.data_in;
        end
    end

    // next occupancy and next head word; a push into an empty (or emptying) FIFO bypasses storage
    always_comb begin
        count_nxt_s = count_r;
        data_nxt_s  = data_out_r;
        if (flush) begin
            count_nxt_s = {CNT_WIDTH{1'b0}};
            data_nxt_s  = {WIDTH{1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_nxt_s = count_r + CNT_WIDTH'(1);
                2'b01:   count_nxt_s = count_r - CNT_WIDTH'(1);
                default: count_nxt_s = count_r;
            endcase
            if (push_s && ((count_r == CNT_WIDTH'(0)) || (pop_s && (count_r == CNT_WIDTH'(1))))) begin
                data_nxt_s = bus.data_in;
            end else if (pop_s && (count_r > CNT_WIDTH'(1))) begin
                data_nxt_s = mem_r[rd_ptr_nxt_s];
            end else begin
                data_nxt_s = data_out_r;
            end
        end
    end

    // registered occupancy and handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r    <= {CNT_WIDTH{1'b0}};
            data_out_r <= {WIDTH{1'b0}};
            vld_out_r  <= 1'b0;
            rdy_in_r   <= 1'b0;
            alive_r    <= 1'b0;
        end else begin
            count_r    <= count_nxt_s;
            data_out_r <= data_nxt_s;
            vld_out_r  <= (count_nxt_s != CNT_WIDTH'(0));
            rdy_in_r   <= (count_nxt_s < CNT_WIDTH'(DEPTH));
            alive_r    <= 1'b1;
        end
    end

    // watermarks follow threshold changes in the same cycle; almost_full held low in reset
    always_comb begin
        status_s              = '{default: 1'b0};
        status_s.count        = STATUS_CNT_WIDTH'(count_r);
        status_s.almost_full  = alive_r & (status_s.count >= STATUS_CNT_WIDTH'(af_thresh));
        status_s.almost_empty = (status_s.count <= STATUS_CNT_WIDTH'(ae_thresh));
    end

    assign count        = count_r;
    assign almost_full  = status_s.almost_full;
    assign almost_empty = status_s.almost_empty;
    assign bus.rdy_in   = rdy_in_r;
    assign bus.vld_out  = vld_out_r;
    assign bus.data_out = data_out_r;

`ifdef AXI_FIFO_LVL_STATS_EN
    logic [CNT_WIDTH-1:0]       peak_r;
    logic [STALL_CNT_WIDTH-1:0] stall_r;

    // high-water mark and saturating upstream stall counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_r  <= {CNT_WIDTH{1'b0}};
            stall_r <= {STALL_CNT_WIDTH{1'b0}};
        end else begin
            if (flush) begin
                peak_r <= {CNT_WIDTH{1'b0}};
            end else if (count_nxt_s > peak_r) begin
                peak_r <= count_nxt_s;
            end else begin
                peak_r <= peak_r;
            end
            if (bus.vld_in && !rdy_in_r && (stall_r != {STALL_CNT_WIDTH{1'b1}})) begin
                stall_r <= stall_r + STALL_CNT_WIDTH'(1);
            end else begin
                stall_r <= stall_r;
            end
        end
    end

    assign peak_count   = peak_r;
    assign stall_cycles = stall_r;
`endif

    axi_fifo_lvl_chk #(.WIDTH(WIDTH)) u_chk (
        .clk     (clk),
        .rst_n   (rst_n),
        .vld_in  (bus.vld_in),
        .rdy_in  (rdy_in_r),
        .data_in (bus.data_in)
    );
endmodule

// File: tb/tb_axi_fifo_lvl.sv
// Directed self-checking bench for axi_fifo_lvl with DEPTH=5, WIDTH=16.
// Statistics checks are included when AXI_FIFO_LVL_STATS_EN is defined.
module tb_axi_fifo_lvl;
    localparam int W  = 16;
    localparam int D  = 5;
    localparam int CW = 3;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic [CW-1:0] af_thresh;
    logic [CW-1:0] ae_thresh;
    logic [CW-1:0] count;
    logic          almost_full;
    logic          almost_empty;
`ifdef AXI_FIFO_LVL_STATS_EN
    logic [CW-1:0] peak_count;
    logic [31:0]   stall_cycles;
`endif

    int n_chk = 0;
    int n_bad = 0;

    axi_fifo_lvl_if #(.WIDTH(W)) bus ();

    axi_fifo_lvl #(.WIDTH(W), .DEPTH(D)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .bus          (bus),
        .af_thresh    (af_thresh),
        .ae_thresh    (ae_thresh),
        .count        (count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`ifdef AXI_FIFO_LVL_STATS_EN
        ,
        .peak_count   (peak_count),
        .stall_cycles (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_n(input int n, input logic [W-1:0] base);
        bus.rdy_out = 1'b0;
        for (int k = 0; k < n; k++) begin
            bus.vld_in  = 1'b1;
            bus.data_in = base + W'(k);
            step();
        end
        bus.vld_in = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        flush       = 1'b0;
        bus.vld_in  = 1'b0;
        bus.data_in = 16'h0000;
        bus.rdy_out = 1'b0;
        af_thresh   = 3'd4;
        ae_thresh   = 3'd1;
        #3;
        chk("rst_vld", 32'(bus.vld_out), 32'd0);
        chk("rst_rdy", 32'(bus.rdy_in), 32'd0);
        chk("rst_cnt", 32'(count), 32'd0);
        chk("rst_af", 32'(almost_full), 32'd0);
        chk("rst_ae", 32'(almost_empty), 32'd1);
        chk("rst_data", 32'(bus.data_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rel_rdy", 32'(bus.rdy_in), 32'd1);
        chk("rel_vld", 32'(bus.vld_out), 32'd0);

        // fill A0..A4 without draining
        for (int i = 0; i < 5; i++) begin
            bus.vld_in  = 1'b1;
            bus.data_in = 16'h00A0 + W'(i);
            step();
            chk("fill_cnt", 32'(count), 32'(i + 1));
            chk("fill_head", 32'(bus.data_out), 32'h00A0);
            chk("fill_af", 32'(almost_full), 32'((i + 1) >= 4));
            chk("fill_ae", 32'(almost_empty), 32'((i + 1) <= 1));
            chk("fill_rdy", 32'(bus.rdy_in), 32'((i + 1) < 5));
        end
        bus.vld_in = 1'b0;
        af_thresh = 3'd6;
        #1 chk("af_above_depth", 32'(almost_full), 32'd0);
        af_thresh = 3'd0;
        #1 chk("af_zero", 32'(almost_full), 32'd1);
        af_thresh = 3'd4;
        #1;

        // drain in order
        bus.rdy_out = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("drain_data", 32'(bus.data_out), 32'h00A0 + 32'(i));
            chk("drain_vld", 32'(bus.vld_out), 32'd1);
            chk("drain_ae", 32'(almost_empty), 32'((5 - i) <= 1));
            step();
        end
        bus.rdy_out = 1'b0;
        chk("drained_vld", 32'(bus.vld_out), 32'd0);
        chk("drained_cnt", 32'(count), 32'd0);

        // streaming at occupancy 2 across pointer wrap
        push_n(2, 16'h00B0);
        for (int i = 0; i < 12; i++) begin
            bus.vld_in  = 1'b1;
            bus.data_in = 16'h00B2 + W'(i);
            bus.rdy_out = 1'b1;
            chk("wrap_data", 32'(bus.data_out), 32'h00B0 + 32'(i));
            step();
            chk("wrap_cnt", 32'(count), 32'd2);
        end
        bus.vld_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("wrap_tail", 32'(bus.data_out), 32'h00BC + 32'(i));
            step();
        end
        bus.rdy_out = 1'b0;
        chk("wrap_empty", 32'(bus.vld_out), 32'd0);

        // push and pop together at count 1
        push_n(1, 16'h0011);
        bus.vld_in  = 1'b1;
        bus.data_in = 16'h0022;
        bus.rdy_out = 1'b1;
        step();
        bus.vld_in = 1'b0;
        chk("byp_data", 32'(bus.data_out), 32'h0022);
        chk("byp_vld", 32'(bus.vld_out), 32'd1);
        chk("byp_cnt", 32'(count), 32'd1);
        step();
        bus.rdy_out = 1'b0;
        chk("byp_empty", 32'(bus.vld_out), 32'd0);

        // flush beats a simultaneous push
        push_n(3, 16'h00C0);
        chk("pre_flush_cnt", 32'(count), 32'd3);
        flush       = 1'b1;
        bus.vld_in  = 1'b1;
        bus.data_in = 16'hDEAD;
        #1 chk("flush_rdy", 32'(bus.rdy_in), 32'd1);
        step();
        flush      = 1'b0;
        bus.vld_in = 1'b0;
        chk("flush_cnt", 32'(count), 32'd0);
        chk("flush_vld", 32'(bus.vld_out), 32'd0);
        chk("flush_rdy_after", 32'(bus.rdy_in), 32'd1);
`ifdef AXI_FIFO_LVL_STATS_EN
        chk("flush_peak", 32'(peak_count), 32'd0);
`endif
        push_n(1, 16'h00D0);
        chk("post_flush_head", 32'(bus.data_out), 32'h00D0);
        chk("post_flush_cnt", 32'(count), 32'd1);
        bus.rdy_out = 1'b1;
        step();
        bus.rdy_out = 1'b0;
        chk("post_flush_empty", 32'(bus.vld_out), 32'd0);

        // hold a word against a full FIFO for 7 cycles
        push_n(5, 16'h00E0);
        bus.vld_in  = 1'b1;
        bus.data_in = 16'hEEEE;
        for (int i = 0; i < 7; i++) step();
        bus.vld_in = 1'b0;
        chk("stall_rdy", 32'(bus.rdy_in), 32'd0);
        chk("stall_cnt", 32'(count), 32'd5);
        chk("stall_head", 32'(bus.data_out), 32'h00E0);
`ifdef AXI_FIFO_LVL_STATS_EN
        chk("stall_cycles", stall_cycles, 32'd7);
        chk("stall_peak", 32'(peak_count), 32'd5);
`endif

        // asynchronous reset with three words held
        flush = 1'b1;
        step();
        flush = 1'b0;
        push_n(3, 16'h00F0);
        chk("pre_rst_cnt", 32'(count), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", 32'(bus.vld_out), 32'd0);
        chk("mid_rst_cnt", 32'(count), 32'd0);
        chk("mid_rst_ae", 32'(almost_empty), 32'd1);
        chk("mid_rst_af", 32'(almost_full), 32'd0);
        chk("mid_rst_rdy", 32'(bus.rdy_in), 32'd0);
`ifdef AXI_FIFO_LVL_STATS_EN
        chk("mid_rst_peak", 32'(peak_count), 32'd0);
        chk("mid_rst_stall", stall_cycles, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("re_rel_rdy", 32'(bus.rdy_in), 32'd1);
        chk("re_rel_vld", 32'(bus.vld_out), 32'd0);
        chk("re_rel_cnt", 32'(count), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
